// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch path.
// Imported by the fetch unit and its next-PC selector.
package mips_pkg;

    localparam int XLEN             = 32;
    localparam int DEF_IMEM_TIMEOUT = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_ERR  = 2'd3
    } fetch_state_e;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{(XLEN-18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next fetch address for the held instruction: jump, taken branch or sequential.
// Purely combinational; the caller decides when the result is used.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [25:0]     instr_idx,
    input  logic            jump,
    input  logic            branch,
    input  logic            bne,
    input  logic            zero,
    output logic [XLEN-1:0] next_pc
);

    logic branch_taken;

    always_comb begin
        branch_taken = (branch & zero) | (bne & ~zero);
        next_pc      = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(instr_idx[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for decode, and picks the next address on hand-off.
//
// state | meaning
// IDLE  | one cycle after reset release, loads RESET_PC as fetch address
// REQ   | imem_req high, waiting for imem_valid (bounded by IMEM_TIMEOUT)
// HOLD  | instruction held stable for decode until instr_ready
// ERR   | memory timed out; terminal until reset
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = DEF_IMEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        bne,
    input  logic        zero,
    output logic        fetch_err
);

    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};
    localparam int          CNT_W      = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             imem_req_q, imem_req_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic [31:0]      pc_plus4_w;
    logic [31:0]      next_pc;

    assign pc_plus4_w = pc_q + 32'd4;

    pc_next_logic u_pc_next (
        .pc_plus4  (pc_plus4_w),
        .instr_idx (instr_q[25:0]),
        .jump      (jump),
        .branch    (branch),
        .bne       (bne),
        .zero      (zero),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            FETCH_IDLE: begin
                state_d    = FETCH_REQ;
                addr_d     = RESET_ADDR;
                wait_cnt_d = '0;
            end
            FETCH_REQ: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    pc_d    = addr_q;
                    state_d = FETCH_HOLD;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = FETCH_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            FETCH_HOLD: begin
                // Control inputs only matter on the hand-off cycle.
                if (instr_ready) begin
                    addr_d     = next_pc & 32'hFFFF_FFFC;
                    wait_cnt_d = '0;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_ERR: begin
                state_d = FETCH_ERR;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
        imem_req_d    = (state_d == FETCH_REQ);
        instr_valid_d = (state_d == FETCH_HOLD);
        fetch_err_d   = (state_d == FETCH_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            addr_q        <= RESET_ADDR;
            instr_q       <= '0;
            pc_q          <= RESET_PC;
            wait_cnt_q    <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            wait_cnt_q    <= wait_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign fetch_err   = fetch_err_q;

endmodule
